// File: rtl/fdc_meas_sequencer.sv
// fdc_meas_sequencer: settle/measure sequencer that counts synchronised sig_in_i rising edges per window
// and hands each count to the readout logic over a valid/ready interface.
// Build option FDC_SEQ_SAT_EN: counter saturates at all-ones and ovf_o flags saturation in the
// reported window; when undefined the counter wraps and ovf_o is tied low.
module fdc_meas_sequencer #(
   parameter int CNT_W      = 16,
   parameter int WIN_W      = 16,
   parameter int SETTLE_CYC = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic             cont_i,
   input  logic [WIN_W-1:0] win_len_i,
   input  logic             sig_in_i,
   input  logic             res_ready_i,
   output logic             fdc_en_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] res_data_o,
   output logic             res_valid_o,
   output logic             lost_o,
   output logic             ovf_o
);
   localparam int SW    = $clog2(SETTLE_CYC + 1);
   localparam int TMR_W = (WIN_W > SW) ? WIN_W : SW;
   typedef enum logic [1:0] {IDLE, SETTLE, MEASURE} state_t;
   state_t           state_q, state_d;
   logic             s1_q, s2_q, prev_q, rise;
   logic [TMR_W-1:0] tmr_q, tmr_d, win_ld;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nx, res_data_q;
   logic             res_valid_q, lost_q, busy_q, fdc_en_q;
   logic             go, win_end, cap, clr;
   // two-flop synchroniser plus previous-value flop for rising-edge detection
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         s1_q   <= sig_in_i;
         s2_q   <= s1_q;
         prev_q <= s2_q;
      end
   assign rise = s2_q & ~prev_q;
`ifdef FDC_SEQ_SAT_EN
   logic sat_q, sat_nx, hit, ovf_q;
   assign hit    = (&cnt_q) & rise;
   assign cnt_nx = hit ? cnt_q : cnt_q + CNT_W'(rise);
   assign sat_nx = sat_q | hit;
   // per-window saturation flag, latched next to each captured result
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sat_q <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         sat_q <= ~clr & sat_nx;
         if (cap) ovf_q <= sat_nx;
      end
   assign ovf_o = ovf_q;
`else
   assign cnt_nx = cnt_q + CNT_W'(rise);
   assign ovf_o  = 1'b0;
`endif
   // next-state, timer reload and counter clear; stop overrides every transition
   always_comb begin
      go      = (state_q == IDLE) & start_i & ~stop_i;
      win_end = (state_q == MEASURE) & (tmr_q == '0);
      cap     = win_end & ~stop_i;
      clr     = (state_q != MEASURE) | stop_i | win_end;
      win_ld  = (win_len_i == '0) ? '0 : TMR_W'(win_len_i) - TMR_W'(1);
      state_d = stop_i ? IDLE :
                (state_q == IDLE) ? (start_i ? SETTLE : IDLE) :
                (state_q == SETTLE) ? ((tmr_q == '0) ? MEASURE : SETTLE) :
                (win_end & ~cont_i) ? IDLE : MEASURE;
      tmr_d   = go ? TMR_W'(SETTLE_CYC - 1) :
                (stop_i | (state_q == IDLE)) ? '0 :
                (tmr_q == '0) ? win_ld : tmr_q - TMR_W'(1);
      cnt_d   = clr ? '0 : cnt_nx;
   end
   // FSM state, registered status outputs and result handshake
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q     <= IDLE;
         tmr_q       <= '0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         fdc_en_q    <= 1'b0;
         res_data_q  <= '0;
         res_valid_q <= 1'b0;
         lost_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         tmr_q       <= tmr_d;
         cnt_q       <= cnt_d;
         busy_q      <= state_d != IDLE;
         fdc_en_q    <= state_d != IDLE;
         if (cap) res_data_q <= cnt_nx;
         res_valid_q <= cap | (res_valid_q & ~res_ready_i);
         lost_q      <= ~go & (lost_q | (cap & res_valid_q & ~res_ready_i));
      end
   assign fdc_en_o    = fdc_en_q;
   assign busy_o      = busy_q;
   assign res_data_o  = res_data_q;
   assign res_valid_o = res_valid_q;
   assign lost_o      = lost_q;
endmodule
